// File: rtl/turf_pkg.sv
// Shared constants, colour decode and state encoding for the playfield scanner.
// Address packing matches the RAM writer's {x, y} layout.
package turf_pkg;

  localparam int X_CELLS = 160;
  localparam int Y_CELLS = 120;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int ADDR_W  = 15;
  localparam int COL_W   = 3;

  // 101..111 are drawable but belong to nobody
  localparam logic [COL_W-1:0] COL_EMPTY = 3'b000;
  localparam logic [COL_W-1:0] COL_P1    = 3'b001;
  localparam logic [COL_W-1:0] COL_P2    = 3'b010;
  localparam logic [COL_W-1:0] COL_P3    = 3'b011;
  localparam logic [COL_W-1:0] COL_P4    = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/turf_scanner_if.sv
// Playfield RAM read port plus VGA adapter plot port seen by the scanner.
// master = scanner side, slave = RAM arbiter / VGA adapter side.
interface turf_scanner_if;
  import turf_pkg::*;

  logic              rd_req;
  logic              rd_gnt;
  logic [ADDR_W-1:0] rd_address;
  logic [COL_W-1:0]  q;
  logic [X_W-1:0]    vga_x;
  logic [Y_W-1:0]    vga_y;
  logic [COL_W-1:0]  vga_colour;
  logic              vga_plot;

  modport master (
    output rd_req, rd_address, vga_x, vga_y, vga_colour, vga_plot,
    input  rd_gnt, q
  );

  modport slave (
    input  rd_req, rd_address, vga_x, vga_y, vga_colour, vga_plot,
    output rd_gnt, q
  );

endinterface

// File: rtl/turf_tally.sv
// Per-player cell counters; a counted cell is visible one cycle after inc_vld.
// latch copies running counts to the score outputs and restarts the tally.
module turf_tally #(
  parameter int SCORE_W = 15
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               inc_vld,
  input  logic [2:0]         colour,
  input  logic               latch,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [SCORE_W-1:0] score_p3,
  output logic [SCORE_W-1:0] score_p4
);
  import turf_pkg::*;

  logic [SCORE_W-1:0] run_p1, run_p2, run_p3, run_p4;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      run_p1   <= '0;
      run_p2   <= '0;
      run_p3   <= '0;
      run_p4   <= '0;
      score_p1 <= '0;
      score_p2 <= '0;
      score_p3 <= '0;
      score_p4 <= '0;
    end else if (latch) begin
      score_p1 <= run_p1;
      score_p2 <= run_p2;
      score_p3 <= run_p3;
      score_p4 <= run_p4;
      run_p1   <= '0;
      run_p2   <= '0;
      run_p3   <= '0;
      run_p4   <= '0;
    end else if (inc_vld) begin
      case (colour)
        COL_P1:  run_p1 <= run_p1 + SCORE_W'(1);
        COL_P2:  run_p2 <= run_p2 + SCORE_W'(1);
        COL_P3:  run_p3 <= run_p3 + SCORE_W'(1);
        COL_P4:  run_p4 <= run_p4 + SCORE_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/turf_scanner.sv
// Sweeps the playfield RAM once per start, plotting every cell one cycle after its granted read.
// Stalls on rd_gnt=0 (address held, no plot); start is ignored while busy.
module turf_scanner #(
  parameter int X_CELLS = 160,
  parameter int Y_CELLS = 120,
  parameter int SCORE_W = 15
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  turf_scanner_if.master     scan,
  output logic               busy,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [SCORE_W-1:0] score_p3,
  output logic [SCORE_W-1:0] score_p4,
  output logic               score_valid
);
  import turf_pkg::*;

  state_e         state, state_nxt;
  logic [X_W-1:0] x, plot_x;
  logic [Y_W-1:0] y, plot_y;
  logic           plot_pend;
  logic           grant;
  logic           x_last;
  logic           last_cell;

  // A grant only counts while we are actually requesting.
  assign grant     = (state == SCAN) && scan.rd_gnt;
  assign x_last    = (x == X_W'(X_CELLS - 1));
  assign last_cell = x_last && (y == Y_W'(Y_CELLS - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (grant && last_cell) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scan.rd_req     = (state == SCAN);
    scan.rd_address = pack_addr(x, y);
    busy            = (state != IDLE);
    score_valid     = (state == DONE);
    scan.vga_x      = plot_x;
    scan.vga_y      = plot_y;
    scan.vga_plot   = plot_pend;
    scan.vga_colour = plot_pend ? scan.q : COL_EMPTY;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE && start) begin
      x <= '0;
      y <= '0;
    end else if (grant) begin
      if (x_last) begin
        x <= '0;
        y <= last_cell ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  // Coordinates travel alongside the read so they line up with q.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      plot_pend <= 1'b0;
      plot_x    <= '0;
      plot_y    <= '0;
    end else begin
      plot_pend <= grant;
      if (grant) begin
        plot_x <= x;
        plot_y <= y;
      end
    end
  end

  turf_tally #(.SCORE_W(SCORE_W)) u_tally (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .inc_vld  (plot_pend),
    .colour   (scan.q),
    .latch    (state == DONE),
    .score_p1 (score_p1),
    .score_p2 (score_p2),
    .score_p3 (score_p3),
    .score_p4 (score_p4)
  );

endmodule

// File: doc/turf_scanner.md
Name: turf_scanner

Overview:
- Read-side counterpart to the game's RAM writer.
- Sweeps the 160x120 playfield RAM (32768x3, address {x[7:0], y[6:0]}) once per start request and streams every cell to the VGA adapter plot interface (x, y, colour, plot).
- Tallies the cells owned by each of the four players and latches the turf scores at the end of each sweep.
- Sits between the shared playfield RAM port (through a grant input) and the VGA adapter / score display.

Parameters:
- X_CELLS, 160, columns swept (x = 0..X_CELLS-1)
- Y_CELLS, 120, rows swept (y = 0..Y_CELLS-1)
- SCORE_W, 15, score counter width (19200 cells fits, no overflow possible)

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sweep when idle
- rd_req  output  1  scanner requests the RAM port this cycle
- rd_gnt  input  1  RAM port granted this cycle (writer has priority)
- rd_address  output  15  {x[7:0], y[6:0]}; meaningful when rd_req=1
- q  input  3  RAM read data; valid one cycle after a granted request
- vga_x  output  8  plot x
- vga_y  output  7  plot y
- vga_colour  output  3  plot colour (raw RAM value)
- vga_plot  output  1  plot strobe, one cycle per cell
- busy  output  1  sweep in progress (any state except IDLE)
- score_p1 .. score_p4  output  15 each  latched cell counts from the last completed sweep
- score_valid  output  1  one-cycle pulse when the scores update

Behaviour:
- Reset (synchronous, overrides everything):
  - State goes to IDLE; x/y counters, running tallies, score_p1..p4, vga_x/y/colour go to 0.
  - rd_req, vga_plot, score_valid, busy go to 0.
  - A reset mid-sweep abandons the sweep; the latched scores are cleared.
- Colour decode, decided here and held in the package:
  - 000 = empty.
  - 001/010/011/100 = player 1/2/3/4 turf.
  - 101-111 are plotted but not counted.
- States:
  - IDLE: start=1 -> SCAN, with x=0, y=0.
  - SCAN: rd_req=1, rd_address={x,y}.
    - Advance only in a cycle with rd_req=1 and rd_gnt=1. Order: x increments first; at x=X_CELLS-1, x wraps to 0 and y increments.
    - A granted request at (X_CELLS-1, Y_CELLS-1) -> DRAIN.
    - rd_gnt=0: hold x/y/rd_address, issue no plot for that cycle.
  - DRAIN: rd_req=0; capture the final data word -> DONE.
  - DONE: copy running tallies into score_p1..p4, pulse score_valid, clear running tallies -> IDLE.
- Read pipeline:
  - 1-stage pipeline: a request granted in cycle t gives q in cycle t+1.
  - In cycle t+1 the block drives vga_x/vga_y = the coordinates registered at t, vga_colour = q, vga_plot = 1.
  - In the same cycle the matching tally increments (registered; visible next cycle).
  - vga_plot=0 in every cycle not preceded by a grant.
- Timing with rd_gnt held at 1:
  - start sampled at edge 0; requests at cycles 1..19200; plots at cycles 2..19201.
  - DRAIN at 19201, score_valid at cycle 19202, busy low from 19203.
- Boundary conditions:
  - start while busy is ignored (no restart, no queueing).
  - start and reset in the same cycle: reset wins.
  - rd_gnt asserted while rd_req=0 is ignored.
  - Addresses with x>=160 or y>=120 are never issued.
  - Scores hold their value between sweeps.

Decomposition:
- Package turf_pkg:
  - X_CELLS, Y_CELLS, ADDR_W=15, COL_W=3.
  - Colour constants COL_EMPTY, COL_P1..COL_P4.
  - State encoding IDLE/SCAN/DRAIN/DONE.
  - An address-pack function {x,y}.
- One natural sub-module, turf_tally: four 15-bit counters with increment-by-colour, clear, and latch-to-score. The top level holds the FSM, coordinate counters and plot pipeline.

Test Plan:
- Reset: drive reset=1 for 2 cycles -> all outputs 0, busy=0, score_p1..p4=0.
- Empty RAM, rd_gnt=1, start at edge 0:
  - exactly 19200 vga_plot pulses, colour 000;
  - first plot (0,0) at cycle 2, last plot (159,119) at cycle 19201;
  - score_valid single pulse at 19202; all scores 0.
- Preload (0,0)=001, ten cells=010, (159,119)=100, (80,60)=110, full grant -> scores 1/10/0/1, and (80,60) plotted with colour 110 but not counted.
- rd_gnt alternating 1,0 -> identical plot sequence with no duplicates or skips, each address held while ungranted, score_valid at cycle 38402.
- start pulsed at plot 100 of a sweep -> ignored; sweep completes once with unchanged counts.
- reset asserted after 5000 plots:
  - vga_plot=0 and busy=0 on the next cycle, scores 0;
  - a new start re-sweeps from (0,0) with correct final scores.
